// File: rtl/mips_pkg.sv
// Shared MIPS-32 memory-stage definitions: load/store opcodes, access sizes,
// FSM state encoding and small decode helpers.
package mips_pkg;

  localparam logic [5:0] OP_LB  = 6'h20;
  localparam logic [5:0] OP_LH  = 6'h21;
  localparam logic [5:0] OP_LW  = 6'h23;
  localparam logic [5:0] OP_LBU = 6'h24;
  localparam logic [5:0] OP_LHU = 6'h25;
  localparam logic [5:0] OP_SB  = 6'h28;
  localparam logic [5:0] OP_SH  = 6'h29;
  localparam logic [5:0] OP_SW  = 6'h2B;

  typedef enum logic [1:0] {
    BYTE = 2'd0,
    HALF = 2'd1,
    WORD = 2'd2
  } acc_size_t;

  typedef logic [0:0] state_t;
  localparam state_t ST_IDLE = 1'b0;
  localparam state_t ST_WAIT = 1'b1;

  typedef struct packed {
    logic      is_mem;
    logic      is_store;
    acc_size_t size;
    logic      is_unsigned;
  } mem_op_t;

  // Anything outside the load/store family decodes as a non-memory op.
  function automatic mem_op_t decode_op(input logic [5:0] op);
    mem_op_t d;
    d = '{is_mem: 1'b0, is_store: 1'b0, size: WORD, is_unsigned: 1'b0};
    case (op)
      OP_LB:  d = '{is_mem: 1'b1, is_store: 1'b0, size: BYTE, is_unsigned: 1'b0};
      OP_LH:  d = '{is_mem: 1'b1, is_store: 1'b0, size: HALF, is_unsigned: 1'b0};
      OP_LW:  d = '{is_mem: 1'b1, is_store: 1'b0, size: WORD, is_unsigned: 1'b0};
      OP_LBU: d = '{is_mem: 1'b1, is_store: 1'b0, size: BYTE, is_unsigned: 1'b1};
      OP_LHU: d = '{is_mem: 1'b1, is_store: 1'b0, size: HALF, is_unsigned: 1'b1};
      OP_SB:  d = '{is_mem: 1'b1, is_store: 1'b1, size: BYTE, is_unsigned: 1'b0};
      OP_SH:  d = '{is_mem: 1'b1, is_store: 1'b1, size: HALF, is_unsigned: 1'b0};
      OP_SW:  d = '{is_mem: 1'b1, is_store: 1'b1, size: WORD, is_unsigned: 1'b0};
      default: ;
    endcase
    return d;
  endfunction

  function automatic logic is_misaligned(input acc_size_t size, input logic [1:0] lo);
    logic bad;
    case (size)
      HALF:    bad = lo[0];
      WORD:    bad = |lo;
      default: bad = 1'b0;
    endcase
    return bad;
  endfunction

  function automatic logic [3:0] byte_enables(input acc_size_t size, input logic [1:0] lo);
    logic [3:0] be;
    case (size)
      BYTE:    be = 4'b0001 << lo;
      HALF:    be = 4'b0011 << lo;
      default: be = 4'b1111;
    endcase
    return be;
  endfunction

endpackage

// File: rtl/load_align.sv
// Picks the addressed byte/halfword lane out of a read word and sign- or
// zero-extends it to 32 bits.
module load_align
  import mips_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  addr_lo,
  input  acc_size_t   size,
  input  logic        is_unsigned,
  output logic [31:0] data
);

  logic [7:0]  lane8;
  logic [15:0] lane16;

  always_comb begin
    lane8 = rdata[7:0];
    case (addr_lo)
      2'd1:    lane8 = rdata[15:8];
      2'd2:    lane8 = rdata[23:16];
      2'd3:    lane8 = rdata[31:24];
      default: lane8 = rdata[7:0];
    endcase
    lane16 = addr_lo[1] ? rdata[31:16] : rdata[15:0];
    case (size)
      BYTE:    data = {{24{~is_unsigned & lane8[7]}}, lane8};
      HALF:    data = {{16{~is_unsigned & lane16[15]}}, lane16};
      default: data = rdata;
    endcase
  end

endmodule

// File: rtl/mem_stage_pipe.sv
// MIPS-32 memory stage: decodes loads/stores, drives a req/ack data-memory
// port, and returns a registered one-cycle result pulse toward write-back.
module mem_stage_pipe
  import mips_pkg::*;
#(
  parameter int ADDR_W   = 32,
  parameter int REG_AW   = 5,
  parameter int MAX_WAIT = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [5:0]        opcode,
  input  logic [31:0]       eff_addr,
  input  logic [31:0]       rt_value,
  input  logic [31:0]       alu_result,
  input  logic [REG_AW-1:0] dest_reg,
  input  logic              reg_write,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [3:0]        mem_be,
  output logic [31:0]       mem_wdata,
  input  logic              mem_ack,
  input  logic [31:0]       mem_rdata,
  output logic              out_valid,
  output logic [31:0]       out_data,
  output logic [REG_AW-1:0] out_dest,
  output logic              out_reg_write,
  output logic              out_misalign,
  output logic              out_bus_err
);

  localparam int CNT_W = $clog2(MAX_WAIT + 1);
  localparam logic [CNT_W-1:0] LAST_WAIT = CNT_W'(MAX_WAIT - 1);

  // Handshake: an instruction transfers on a rising edge where in_valid and
  // in_ready are both high; in_ready is low for the whole memory access.
  state_t            state;
  logic [CNT_W-1:0]  wait_cnt;
  acc_size_t         lat_size;
  logic              lat_unsigned;
  logic              lat_store;
  logic [1:0]        lat_lo;
  logic [REG_AW-1:0] lat_dest;
  logic              lat_rw;

  mem_op_t     dec;
  logic        accept;
  logic        misalign;
  logic [31:0] store_data;
  logic [31:0] load_data;

  assign in_ready = (state == ST_IDLE);
  assign accept   = in_valid & in_ready;
  assign dec      = decode_op(opcode);
  assign misalign = is_misaligned(dec.size, eff_addr[1:0]);

  always_comb begin
    case (dec.size)
      BYTE:    store_data = {4{rt_value[7:0]}};
      HALF:    store_data = {2{rt_value[15:0]}};
      default: store_data = rt_value;
    endcase
  end

  load_align u_load_align (
    .rdata       (mem_rdata),
    .addr_lo     (lat_lo),
    .size        (lat_size),
    .is_unsigned (lat_unsigned),
    .data        (load_data)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= ST_IDLE;
      wait_cnt      <= '0;
      lat_size      <= WORD;
      lat_unsigned  <= 1'b0;
      lat_store     <= 1'b0;
      lat_lo        <= 2'b00;
      lat_dest      <= '0;
      lat_rw        <= 1'b0;
      mem_req       <= 1'b0;
      mem_we        <= 1'b0;
      mem_addr      <= '0;
      mem_be        <= 4'b0000;
      mem_wdata     <= '0;
      out_valid     <= 1'b0;
      out_data      <= '0;
      out_dest      <= '0;
      out_reg_write <= 1'b0;
      out_misalign  <= 1'b0;
      out_bus_err   <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            if (!dec.is_mem) begin
              out_valid     <= 1'b1;
              out_data      <= alu_result;
              out_dest      <= dest_reg;
              out_reg_write <= reg_write;
              out_misalign  <= 1'b0;
              out_bus_err   <= 1'b0;
            end else if (misalign) begin
              out_valid     <= 1'b1;
              out_dest      <= dest_reg;
              out_reg_write <= 1'b0;
              out_misalign  <= 1'b1;
              out_bus_err   <= 1'b0;
            end else begin
              mem_req      <= 1'b1;
              mem_we       <= dec.is_store;
              mem_addr     <= {eff_addr[ADDR_W-1:2], 2'b00};
              mem_be       <= byte_enables(dec.size, eff_addr[1:0]);
              mem_wdata    <= store_data;
              wait_cnt     <= '0;
              lat_size     <= dec.size;
              lat_unsigned <= dec.is_unsigned;
              lat_store    <= dec.is_store;
              lat_lo       <= eff_addr[1:0];
              lat_dest     <= dest_reg;
              lat_rw       <= reg_write;
              state        <= ST_WAIT;
            end
          end
        end
        ST_WAIT: begin
          // An ack in the final allowed cycle still completes normally.
          if (mem_ack) begin
            mem_req       <= 1'b0;
            out_valid     <= 1'b1;
            if (!lat_store) out_data <= load_data;
            out_dest      <= lat_dest;
            out_reg_write <= lat_rw & ~lat_store;
            out_misalign  <= 1'b0;
            out_bus_err   <= 1'b0;
            state         <= ST_IDLE;
          end else if (wait_cnt == LAST_WAIT) begin
            mem_req       <= 1'b0;
            out_valid     <= 1'b1;
            out_dest      <= lat_dest;
            out_reg_write <= 1'b0;
            out_misalign  <= 1'b0;
            out_bus_err   <= 1'b1;
            state         <= ST_IDLE;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage_pipe.sv
// Directed bench for mem_stage_pipe: a memory responder checks each request,
// and a scoreboard monitor checks every write-back pulse against exp_q.
module tb_mem_stage_pipe;
  import mips_pkg::*;

  localparam int MAX_WAIT = 4;
  localparam int OW = 41; // {care_data, data[31:0], dest[4:0], rw, misalign, bus_err}
  localparam int MW = 70; // {care_wdata, we, addr[31:0], be[3:0], wdata[31:0]}

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [5:0]  opcode;
  logic [31:0] eff_addr, rt_value, alu_result;
  logic [4:0]  dest_reg;
  logic        reg_write;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        out_valid;
  logic [31:0] out_data;
  logic [4:0]  out_dest;
  logic        out_reg_write, out_misalign, out_bus_err;

  int vectors = 0;
  int miscompares = 0;

  logic [OW-1:0] exp_q[$];
  logic [MW-1:0] mem_q[$];
  int            delay_q[$];
  logic [31:0]   rdata_q[$];

  int run_len = 0;
  int max_run = 0;

  mem_stage_pipe #(.ADDR_W(32), .REG_AW(5), .MAX_WAIT(MAX_WAIT)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .opcode(opcode), .eff_addr(eff_addr), .rt_value(rt_value),
    .alu_result(alu_result), .dest_reg(dest_reg), .reg_write(reg_write),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .out_valid(out_valid), .out_data(out_data), .out_dest(out_dest),
    .out_reg_write(out_reg_write), .out_misalign(out_misalign),
    .out_bus_err(out_bus_err)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // ---------------- helpers ----------------
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic exp_out(input logic care, input logic [31:0] data, input logic [4:0] dest,
                         input logic rw, input logic mis, input logic bus);
    exp_q.push_back({care, data, dest, rw, mis, bus});
  endtask

  task automatic exp_mem(input logic care_wd, input logic we, input logic [31:0] addr,
                         input logic [3:0] be, input logic [31:0] wdata,
                         input int delay, input logic [31:0] rdata);
    mem_q.push_back({care_wd, we, addr, be, wdata});
    delay_q.push_back(delay);
    rdata_q.push_back(rdata);
  endtask

  // ---------------- driver tasks (called at a negedge) ----------------
  task automatic send(input logic [5:0] op, input logic [31:0] addr, input logic [31:0] rt,
                      input logic [31:0] alu, input logic [4:0] dest, input logic rw);
    int n;
    opcode = op; eff_addr = addr; rt_value = rt; alu_result = alu;
    dest_reg = dest; reg_write = rw; in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) chk("send_timeout", 64'(in_ready), 64'd1);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_ready(output int n);
    n = 0;
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || mem_req) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) chk("drain_timeout", 64'(exp_q.size()), 64'd0);
    @(negedge clk);
  endtask

  // ---------------- memory responder ----------------
  logic          active = 1'b0;
  int            cyc;
  int            cur_delay;
  logic [MW-1:0] cur_req;

  always @(negedge clk or posedge rst) begin
    if (rst) begin
      active  = 1'b0;
      mem_ack = 1'b0;
    end else begin
      mem_ack = 1'b0;
      if (mem_req) begin
        if (!active) begin
          active = 1'b1;
          cyc = 0;
          if (mem_q.size() == 0) begin
            chk("mem_unexpected_req", 64'(mem_req), 64'd0);
            cur_req = {1'b0, mem_we, mem_addr, mem_be, mem_wdata};
            cur_delay = 1;
          end else begin
            cur_req   = mem_q.pop_front();
            cur_delay = delay_q.pop_front();
            mem_rdata = rdata_q.pop_front();
            chk("mem_we",   64'(mem_we),   64'(cur_req[68]));
            chk("mem_addr", 64'(mem_addr), 64'(cur_req[67:36]));
            chk("mem_be",   64'(mem_be),   64'(cur_req[35:32]));
            if (cur_req[69]) chk("mem_wdata", 64'(mem_wdata), 64'(cur_req[31:0]));
            cur_req = {1'b0, mem_we, mem_addr, mem_be, mem_wdata};
          end
        end else begin
          chk("mem_hold", 64'({mem_we, mem_addr, mem_be, mem_wdata}), 64'(cur_req[68:0]));
        end
        cyc++;
        if (cyc == cur_delay) mem_ack = 1'b1;
      end else if (active) begin
        active = 1'b0;
        chk("mem_req_len", 64'(cyc), 64'(cur_delay == 0 ? MAX_WAIT : cur_delay));
      end
    end
  end

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    if (!rst) begin
      if (out_valid) begin
        run_len++;
        if (run_len > max_run) max_run = run_len;
        if (exp_q.size() == 0) begin
          chk("out_unexpected_valid", 64'(out_valid), 64'd0);
        end else begin
          logic [OW-1:0] e;
          logic [OW-1:0] a;
          e = exp_q.pop_front();
          a = {e[40], out_data, out_dest, out_reg_write, out_misalign, out_bus_err};
          if (!e[40]) a[39:8] = e[39:8];
          chk("out_result", 64'(a), 64'(e));
        end
      end else begin
        run_len = 0;
      end
    end
  end

  // ---------------- directed stimulus ----------------
  initial begin
    int n;
    rst = 1'b1; in_valid = 1'b0; opcode = '0; eff_addr = '0; rt_value = '0;
    alu_result = '0; dest_reg = '0; reg_write = 1'b0; mem_ack = 1'b0; mem_rdata = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("reset_in_ready", 64'(in_ready), 64'd1);
    chk("reset_mem", 64'({mem_req, mem_we, mem_be}), 64'd0);
    chk("reset_mem_addr", 64'(mem_addr), 64'd0);
    chk("reset_mem_wdata", 64'(mem_wdata), 64'd0);
    chk("reset_out_flags", 64'({out_valid, out_reg_write, out_misalign, out_bus_err}), 64'd0);
    chk("reset_out_data", 64'({out_data, out_dest}), 64'd0);
    @(negedge clk);

    // lw with ack on third wait cycle
    exp_mem(1'b0, 1'b0, 32'h100, 4'b1111, 32'h0, 3, 32'hDEADBEEF);
    exp_out(1'b1, 32'hDEADBEEF, 5'd5, 1'b1, 1'b0, 1'b0);
    send(OP_LW, 32'h100, 32'h0, 32'h0, 5'd5, 1'b1);
    wait_ready(n);
    chk("lw_stall_cycles", 64'(n), 64'd3);
    drain();

    // lb / lbu lane 3
    exp_mem(1'b0, 1'b0, 32'h200, 4'b1000, 32'h0, 1, 32'h80FF0000);
    exp_out(1'b1, 32'hFFFFFF80, 5'd6, 1'b1, 1'b0, 1'b0);
    send(OP_LB, 32'h203, 32'h0, 32'h0, 5'd6, 1'b1);
    drain();
    exp_mem(1'b0, 1'b0, 32'h200, 4'b1000, 32'h0, 1, 32'h80FF0000);
    exp_out(1'b1, 32'h00000080, 5'd7, 1'b1, 1'b0, 1'b0);
    send(OP_LBU, 32'h203, 32'h0, 32'h0, 5'd7, 1'b1);
    drain();

    // lh / lhu upper and lower halves
    exp_mem(1'b0, 1'b0, 32'h200, 4'b1100, 32'h0, 2, 32'h80017FFF);
    exp_out(1'b1, 32'hFFFF8001, 5'd8, 1'b1, 1'b0, 1'b0);
    send(OP_LH, 32'h202, 32'h0, 32'h0, 5'd8, 1'b1);
    drain();
    exp_mem(1'b0, 1'b0, 32'h200, 4'b1100, 32'h0, 1, 32'h80017FFF);
    exp_out(1'b1, 32'h00008001, 5'd9, 1'b1, 1'b0, 1'b0);
    send(OP_LHU, 32'h202, 32'h0, 32'h0, 5'd9, 1'b1);
    drain();
    exp_mem(1'b0, 1'b0, 32'h200, 4'b0011, 32'h0, 1, 32'h80017FFF);
    exp_out(1'b1, 32'h00007FFF, 5'd10, 1'b1, 1'b0, 1'b0);
    send(OP_LH, 32'h200, 32'h0, 32'h0, 5'd10, 1'b1);
    drain();

    // stores: sh upper half, sb lane 1
    exp_mem(1'b1, 1'b1, 32'h300, 4'b1100, 32'hABCDABCD, 2, 32'h0);
    exp_out(1'b0, 32'h0, 5'd11, 1'b0, 1'b0, 1'b0);
    send(OP_SH, 32'h302, 32'h1234ABCD, 32'h0, 5'd11, 1'b1);
    drain();
    exp_mem(1'b1, 1'b1, 32'h100, 4'b0010, 32'h55555555, 1, 32'h0);
    exp_out(1'b0, 32'h0, 5'd12, 1'b0, 1'b0, 1'b0);
    send(OP_SB, 32'h101, 32'h00000055, 32'h0, 5'd12, 1'b1);
    drain();

    // misaligned word and halfword
    exp_out(1'b0, 32'h0, 5'd13, 1'b0, 1'b1, 1'b0);
    send(OP_LW, 32'h402, 32'h0, 32'h0, 5'd13, 1'b1);
    chk("misalign_latency", 64'(out_valid), 64'd1);
    drain();
    exp_out(1'b0, 32'h0, 5'd14, 1'b0, 1'b1, 1'b0);
    send(OP_SH, 32'h101, 32'h0, 32'h0, 5'd14, 1'b1);
    chk("misalign_no_req", 64'(mem_req), 64'd0);
    drain();

    // sw timeout, then ack on the last allowed cycle
    exp_mem(1'b1, 1'b1, 32'h600, 4'b1111, 32'hCAFEF00D, 0, 32'h0);
    exp_out(1'b0, 32'h0, 5'd15, 1'b0, 1'b0, 1'b1);
    send(OP_SW, 32'h600, 32'hCAFEF00D, 32'h0, 5'd15, 1'b1);
    wait_ready(n);
    chk("timeout_stall_cycles", 64'(n), 64'(MAX_WAIT));
    drain();
    exp_mem(1'b1, 1'b1, 32'h604, 4'b1111, 32'h01020304, MAX_WAIT, 32'h0);
    exp_out(1'b0, 32'h0, 5'd16, 1'b0, 1'b0, 1'b0);
    send(OP_SW, 32'h604, 32'h01020304, 32'h0, 5'd16, 1'b1);
    drain();

    // stray ack while idle must be ignored
    @(negedge clk);
    #1 mem_ack = 1'b1;
    repeat (3) @(negedge clk);
    chk("stray_ack_idle", 64'({in_ready, mem_req}), 64'b10);

    // back-to-back non-memory ops, including an unknown opcode
    max_run = 0;
    exp_out(1'b1, 32'h11111111, 5'd1, 1'b1, 1'b0, 1'b0);
    exp_out(1'b1, 32'h22222222, 5'd2, 1'b0, 1'b0, 1'b0);
    exp_out(1'b1, 32'h33333333, 5'd3, 1'b1, 1'b0, 1'b0);
    send(6'h00, 32'h0, 32'h0, 32'h11111111, 5'd1, 1'b1);
    chk("alu_latency", 64'(out_valid), 64'd1);
    send(6'h3F, 32'h3, 32'h0, 32'h22222222, 5'd2, 1'b0);
    send(6'h0F, 32'h1, 32'h0, 32'h33333333, 5'd3, 1'b1);
    @(negedge clk);
    chk("alu_back_to_back_run", 64'(max_run), 64'd3);
    drain();

    // reset while waiting on memory abandons the access
    exp_mem(1'b1, 1'b1, 32'h704, 4'b1111, 32'h0BADF00D, 0, 32'h0);
    send(OP_SW, 32'h704, 32'h0BADF00D, 32'h0, 5'd17, 1'b1);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("reset_drops_req", 64'(mem_req), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("reset_release_ready", 64'(in_ready), 64'd1);
    repeat (MAX_WAIT + 2) @(negedge clk);
    chk("reset_no_out_valid", 64'(exp_q.size()), 64'd0);

    // recovery after reset
    exp_mem(1'b0, 1'b0, 32'h800, 4'b1111, 32'h0, 1, 32'h13579BDF);
    exp_out(1'b1, 32'h13579BDF, 5'd18, 1'b1, 1'b0, 1'b0);
    send(OP_LW, 32'h800, 32'h0, 32'h0, 5'd18, 1'b1);
    drain();

    chk("exp_q_empty", 64'(exp_q.size()), 64'd0);
    chk("mem_q_empty", 64'(mem_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
